// File: rtl/alu_result_reader.sv
// ---------------------------------------------------------------------------
// alu_result_reader
//
// Purpose:
//   Reads the ALU's multiplexed 8-bit output bus. The bus carries the result
//   byte when sel_out = 0 and {4'b0, C, V, N, Z} when sel_out = 1. This block
//   drives the select line itself, waits SETTLE_CYCLES after each change,
//   captures the result and then the flag nibble, and offers the pair on a
//   valid/ready output port for a downstream consumer.
//
// Ports:
//   clk          in   1  single clock, rising edge
//   rst_n        in   1  asynchronous active-low reset
//   start        in   1  capture request, only looked at in IDLE
//   auto_en      in   1  1 = start the next capture right after each transfer
//   uo_in        in   8  ALU multiplexed output bus
//   sel_out      out  1  ALU select: 0 = result, 1 = flags (registered)
//   busy         out  1  high whenever the reader is not idle
//   out_valid    out  1  captured pair available
//   out_ready    in   1  consumer accepts the pair
//   out_result   out  8  captured result byte
//   out_flags    out  4  captured {Carry, Overflow, Negative, Zero}
//   out_changed  out  1  current pair differs from the previously delivered one
//   flag_err     out  1  upper nibble of the bus was non-zero at flag capture
//
// Parameters:
//   SETTLE_CYCLES  cycles the select line is held before each capture (1..255)
// ---------------------------------------------------------------------------
module alu_result_reader #(
   parameter int SETTLE_CYCLES = 2
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic       auto_en,
   input  logic [7:0] uo_in,
   output logic       sel_out,
   output logic       busy,
   output logic       out_valid,
   input  logic       out_ready,
   output logic [7:0] out_result,
   output logic [3:0] out_flags,
   output logic       out_changed,
   output logic       flag_err
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WR    = 2'd1,
      WF    = 2'd2,
      VALID = 2'd3
   } state_t;

   // Counter value seen in the final cycle of a settle window.
   localparam logic [7:0] LAST_COUNT = 8'(SETTLE_CYCLES - 1);

   state_t      state;
   state_t      next_state;
   logic [7:0]  settle_cnt;
   logic        settle_done;
   logic        transfer;
   logic [11:0] prev_pair;

   assign settle_done = (settle_cnt == LAST_COUNT);
   assign transfer    = (state == VALID) && out_ready;

   // State register. Reset aborts any capture in progress at once.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Next-state logic. start only matters in IDLE, so a request made while
   // busy is dropped rather than queued. auto_en is looked at only on the
   // transfer edge, which lets software clear it mid-capture and still get
   // the pair that is already in flight.
   always_comb begin
      next_state = state;
      case (state)
         IDLE: begin
            if (start) begin
               next_state = WR;
            end
         end
         WR: begin
            if (settle_done) begin
               next_state = WF;
            end
         end
         WF: begin
            if (settle_done) begin
               next_state = VALID;
            end
         end
         VALID: begin
            if (out_ready) begin
               next_state = auto_en ? WR : IDLE;
            end
         end
         default: begin
            next_state = IDLE;
         end
      endcase
   end

   // Settle counter. It restarts from zero on every entry into WR or WF, so
   // each window is exactly SETTLE_CYCLES cycles long regardless of how it
   // was entered (start from IDLE or auto restart from VALID).
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         settle_cnt <= 8'd0;
      end else begin
         case (state)
            WR, WF: begin
               if (settle_done) begin
                  settle_cnt <= 8'd0;
               end else begin
                  settle_cnt <= settle_cnt + 8'd1;
               end
            end
            default: begin
               settle_cnt <= 8'd0;
            end
         endcase
      end
   end

   // Control outputs are flops fed from the next state, so they change only
   // at state boundaries and the ALU select line never glitches.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sel_out   <= 1'b0;
         busy      <= 1'b0;
         out_valid <= 1'b0;
      end else begin
         sel_out   <= (next_state == WF);
         busy      <= (next_state != IDLE);
         out_valid <= (next_state == VALID);
      end
   end

   // Data capture. The result byte is taken at the end of the WR window and
   // the flag nibble at the end of the WF window. Nothing here is written in
   // VALID, which keeps the offered pair stable until it is accepted.
   // out_changed compares the freshly assembled pair against the last pair
   // that was actually handed to the consumer.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_result  <= 8'd0;
         out_flags   <= 4'd0;
         out_changed <= 1'b0;
         flag_err    <= 1'b0;
      end else begin
         if ((state == WR) && settle_done) begin
            out_result <= uo_in;
         end
         if ((state == WF) && settle_done) begin
            out_flags   <= uo_in[3:0];
            flag_err    <= |uo_in[7:4];
            out_changed <= ({uo_in[3:0], out_result} != prev_pair);
         end
      end
   end

   // Last delivered pair, {flags, result}. It starts at all zeros so a first
   // capture of 0x00 / 0x0 after reset reports no change.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         prev_pair <= 12'd0;
      end else if (transfer) begin
         prev_pair <= {out_flags, out_result};
      end
   end

endmodule

// File: tb/tb_alu_result_reader.sv
// ---------------------------------------------------------------------------
// tb_alu_result_reader
//
// Directed bench for alu_result_reader. Two instances are used: dut_a with
// SETTLE_CYCLES = 2 and dut_b with SETTLE_CYCLES = 1. The ALU bus is modelled
// as a mux of two bench-owned bytes controlled by each DUT's select line.
// ---------------------------------------------------------------------------
module tb_alu_result_reader;

   logic       clk = 1'b0;
   logic       rst_n;

   logic [7:0] res_byte;
   logic [7:0] flag_byte;

   logic       start_a, auto_a, ready_a;
   logic [7:0] uo_a;
   logic       sel_a, busy_a, valid_a, changed_a, err_a;
   logic [7:0] result_a;
   logic [3:0] flags_a;

   logic       start_b, auto_b, ready_b;
   logic [7:0] uo_b;
   logic       sel_b, busy_b, valid_b, changed_b, err_b;
   logic [7:0] result_b;
   logic [3:0] flags_b;

   int n_compared   = 0;
   int n_mismatched = 0;

   // Free-running clock, 10 ns period.
   always #5 clk = ~clk;

   // ALU output mux model: result byte on select 0, flag byte on select 1.
   assign uo_a = sel_a ? flag_byte : res_byte;
   assign uo_b = sel_b ? flag_byte : res_byte;

   alu_result_reader #(.SETTLE_CYCLES(2)) dut_a (
      .clk(clk), .rst_n(rst_n), .start(start_a), .auto_en(auto_a),
      .uo_in(uo_a), .sel_out(sel_a), .busy(busy_a), .out_valid(valid_a),
      .out_ready(ready_a), .out_result(result_a), .out_flags(flags_a),
      .out_changed(changed_a), .flag_err(err_a)
   );

   alu_result_reader #(.SETTLE_CYCLES(1)) dut_b (
      .clk(clk), .rst_n(rst_n), .start(start_b), .auto_en(auto_b),
      .uo_in(uo_b), .sel_out(sel_b), .busy(busy_b), .out_valid(valid_b),
      .out_ready(ready_b), .out_result(result_b), .out_flags(flags_b),
      .out_changed(changed_b), .flag_err(err_b)
   );

   // Single comparison point: counts and reports mismatches.
   task automatic checkOutput(input string tag, input logic [31:0] actual,
                              input logic [31:0] expected);
      n_compared++;
      if (actual !== expected) begin
         n_mismatched++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
      end
   endtask

   // Sets the two bytes the modelled ALU presents on its bus.
   task automatic applyStimulus(input logic [7:0] r, input logic [7:0] f);
      res_byte  = r;
      flag_byte = f;
   endtask

   // Pulses start on dut_a and waits (bounded) for out_valid; the cycle in
   // which valid first appears must be 2S+1 = 5.
   task automatic captureA(input string tag);
      int lat;
      start_a = 1'b1;
      @(negedge clk);
      start_a = 1'b0;
      lat = 1;
      while (!valid_a && lat < 40) begin
         @(negedge clk);
         lat++;
      end
      checkOutput({tag, "_latency"}, lat, 5);
   endtask

   // Accepts the pair offered by dut_a and checks the handshake closed it.
   task automatic releaseA(input string tag);
      ready_a = 1'b1;
      @(negedge clk);
      ready_a = 1'b0;
      checkOutput({tag, "_valid_drop"}, valid_a, 0);
      checkOutput({tag, "_idle"}, busy_a, 0);
   endtask

   // Watchdog so the run always ends.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      logic exp_sel [1:6];
      logic exp_val [1:6];
      logic exp_bsy [1:6];

      rst_n   = 1'b0;
      start_a = 1'b0; auto_a = 1'b0; ready_a = 1'b0;
      start_b = 1'b0; auto_b = 1'b0; ready_b = 1'b0;
      applyStimulus(8'h00, 8'h00);
      repeat (3) @(negedge clk);

      // Reset state
      checkOutput("rst_sel",     sel_a, 0);
      checkOutput("rst_busy",    busy_a, 0);
      checkOutput("rst_valid",   valid_a, 0);
      checkOutput("rst_result",  result_a, 0);
      checkOutput("rst_flags",   flags_a, 0);
      checkOutput("rst_changed", changed_a, 0);
      checkOutput("rst_err",     err_a, 0);
      rst_n = 1'b1;
      @(negedge clk);

      // Test 1: cycle-accurate timeline, S = 2, out_ready held high.
      $display("[TB] test 1: basic capture timeline");
      exp_sel = '{0, 0, 1, 1, 0, 0};
      exp_val = '{0, 0, 0, 0, 1, 0};
      exp_bsy = '{1, 1, 1, 1, 1, 0};
      applyStimulus(8'h5A, 8'h05);
      ready_a = 1'b1;
      start_a = 1'b1;
      for (int c = 1; c <= 6; c++) begin
         @(negedge clk);
         start_a = 1'b0;
         checkOutput($sformatf("t1_sel_c%0d", c),   sel_a,   exp_sel[c]);
         checkOutput($sformatf("t1_valid_c%0d", c), valid_a, exp_val[c]);
         checkOutput($sformatf("t1_busy_c%0d", c),  busy_a,  exp_bsy[c]);
         if (c == 5) begin
            checkOutput("t1_result",  result_a,  8'h5A);
            checkOutput("t1_flags",   flags_a,   4'b0101);
            checkOutput("t1_err",     err_a,     0);
            checkOutput("t1_changed", changed_a, 1);
         end
      end
      ready_a = 1'b0;

      // Test 2: same pair again reports no change; new result reports change.
      $display("[TB] test 2: change detection");
      captureA("t2a");
      checkOutput("t2a_result",  result_a,  8'h5A);
      checkOutput("t2a_changed", changed_a, 0);
      releaseA("t2a");
      applyStimulus(8'h5B, 8'h05);
      captureA("t2b");
      checkOutput("t2b_result",  result_a,  8'h5B);
      checkOutput("t2b_changed", changed_a, 1);
      releaseA("t2b");

      // Test 3: back-pressure for 10 cycles while the bus keeps changing.
      $display("[TB] test 3: hold under back-pressure");
      applyStimulus(8'h3C, 8'h08);
      captureA("t3");
      for (int i = 0; i < 10; i++) begin
         applyStimulus(8'(i * 7 + 1), 8'(i));
         @(negedge clk);
         checkOutput($sformatf("t3_valid_%0d", i),  valid_a,  1);
         checkOutput($sformatf("t3_result_%0d", i), result_a, 8'h3C);
         checkOutput($sformatf("t3_flags_%0d", i),  flags_a,  4'h8);
      end
      checkOutput("t3_changed", changed_a, 1);
      releaseA("t3");

      // Test 5: non-zero upper nibble during the flag phase.
      $display("[TB] test 5: flag error");
      applyStimulus(8'h12, 8'h93);
      captureA("t5");
      checkOutput("t5_result", result_a, 8'h12);
      checkOutput("t5_flags",  flags_a,  4'b0011);
      checkOutput("t5_err",    err_a,    1);
      releaseA("t5");

      // Test 6: reset asserted during the flag window.
      $display("[TB] test 6: reset during flag phase");
      applyStimulus(8'h77, 8'h01);
      start_a = 1'b1;
      @(negedge clk);
      start_a = 1'b0;
      @(negedge clk);
      @(negedge clk);
      checkOutput("t6_in_wf", sel_a, 1);
      #2 rst_n = 1'b0;
      #1;
      checkOutput("t6_rst_sel",     sel_a, 0);
      checkOutput("t6_rst_busy",    busy_a, 0);
      checkOutput("t6_rst_valid",   valid_a, 0);
      checkOutput("t6_rst_result",  result_a, 0);
      checkOutput("t6_rst_flags",   flags_a, 0);
      checkOutput("t6_rst_changed", changed_a, 0);
      checkOutput("t6_rst_err",     err_a, 0);
      @(negedge clk);
      rst_n = 1'b1;
      applyStimulus(8'h00, 8'h00);
      @(negedge clk);
      checkOutput("t6_no_stale", result_a, 0);
      captureA("t6");
      checkOutput("t6_result",  result_a,  0);
      checkOutput("t6_flags",   flags_a,   0);
      checkOutput("t6_changed", changed_a, 0);
      checkOutput("t6_err",     err_a,     0);
      releaseA("t6");

      // Test 4: auto mode with S = 1, one pair every 3 cycles; auto_en
      // cleared during the third capture ends the loop after that pair.
      $display("[TB] test 4: auto mode");
      applyStimulus(8'h44, 8'h02);
      ready_b = 1'b1;
      auto_b  = 1'b1;
      start_b = 1'b1;
      for (int c = 1; c <= 12; c++) begin
         @(negedge clk);
         start_b = 1'b0;
         checkOutput($sformatf("t4_valid_c%0d", c), valid_b,
                     (c == 3 || c == 6 || c == 9) ? 1 : 0);
         checkOutput($sformatf("t4_busy_c%0d", c), busy_b, (c <= 9) ? 1 : 0);
         if (c == 3) begin
            checkOutput("t4_result", result_b, 8'h44);
            checkOutput("t4_flags",  flags_b,  4'h2);
         end
         if (c == 7) begin
            auto_b = 1'b0;
         end
      end
      ready_b = 1'b0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
      $finish;
   end

endmodule
